// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg: shared types and constants for the stream-to-Wishbone writer
package wb_stream_pkg;
  localparam int WORD_BYTES = 4;
  localparam logic [3:0] SEL_FULL = 4'b1111;
  typedef struct packed {
    logic        sof;
    logic [31:0] data;
  } fifo_entry_t;
  typedef enum logic {IDLE, WRITE} wr_state_t;
endpackage

// File: rtl/wb_stream_writer_if.sv
// wshb_if: Wishbone classic bundle (cyc/stb/we/adr/sel/dat_ms from master; ack/dat_sm from slave)
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  modport master (input clk, rst, ack, dat_sm, output cyc, stb, we, adr, sel, dat_ms);
  modport slave (input clk, rst, cyc, stb, we, adr, sel, dat_ms, output ack, dat_sm);
endinterface

// File: rtl/wb_stream_writer_fifo.sv
// stream_fifo: sync FWFT FIFO; ports clk, rst, push, pop, din, full, empty, head, count
module stream_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/wb_stream_writer.sv
// wb_stream_writer: buffers a sof-tagged word stream and writes it to a wrapping Wishbone frame; ports clk, rst, in_*, wb_m, frame_done
module wb_stream_writer
  import wb_stream_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] BASE_ADR    = 32'h0,
  parameter int          FRAME_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sof,
  wshb_if.master      wb_m,
  output logic        frame_done
);
  localparam int PW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PW-1:0] LAST = PW'(FRAME_WORDS - 1);
  fifo_entry_t head, din;
  logic full, empty, push, pop, stb;
  logic [CW-1:0] count, next_count;
  logic [PW-1:0] ptr, ptr_eff;
  wr_state_t state;
  assign in_ready = !full && !rst;
  assign push = in_valid && in_ready;
  assign pop = stb && wb_m.ack;
  assign din = '{sof: in_sof, data: in_data};
  assign ptr_eff = head.sof ? '0 : ptr;
  // state mirrors the FIFO occupancy after this edge so stb is a flop yet rises the cycle after a push
  assign next_count = count + CW'(push) - CW'(pop);
  stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fifo_entry_t))) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .full(full), .empty(empty), .head(head), .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= next_count != '0 ? WRITE : IDLE;
      frame_done <= pop && ptr_eff == LAST;
      if (pop) ptr <= ptr_eff == LAST ? '0 : ptr_eff + 1'b1;
    end
  end
  assign stb = state == WRITE;
  assign wb_m.stb = stb;
  assign wb_m.cyc = stb;
  assign wb_m.we = stb;
  assign wb_m.sel = stb ? SEL_FULL : 4'b0000;
  assign wb_m.adr = stb ? BASE_ADR + 32'(ptr_eff) * 32'(WORD_BYTES) : BASE_ADR;
  assign wb_m.dat_ms = stb ? head.data : 32'h0;
endmodule

// File: tb/tb_wb_stream_writer.sv
// tb_wb_stream_writer: directed self-checking bench for wb_stream_writer
module tb_wb_stream_writer;
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    int          cyc;
  } ent_t;
  logic clk = 0, rst = 1;
  logic in_valid0 = 0, in_valid1 = 0, in_sof = 0;
  logic [31:0] in_data = 0;
  logic in_ready0, in_ready1, frame_done0, frame_done1;
  logic hold = 0, force_ack = 0;
  int ack_delay = 0, wcnt = 0, cyc_n = 0;
  int fd0 = 0, fd1 = 0, fd1_cyc = -1;
  int errors = 0, checks = 0;
  ent_t log0[$], log1[$];
  logic [31:0] mem [2048];
  always #5 clk = ~clk;
  wshb_if bus0 (.clk(clk), .rst(rst));
  wshb_if bus1 (.clk(clk), .rst(rst));
  wb_stream_writer #(.FIFO_DEPTH(8), .BASE_ADR(32'h0), .FRAME_WORDS(2048)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data),
    .in_sof(in_sof), .wb_m(bus0), .frame_done(frame_done0)
  );
  wb_stream_writer #(.FIFO_DEPTH(8), .BASE_ADR(32'h0), .FRAME_WORDS(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
    .in_sof(in_sof), .wb_m(bus1), .frame_done(frame_done1)
  );
  assign bus0.ack = force_ack | (bus0.stb && !hold && wcnt >= ack_delay);
  assign bus0.dat_sm = 32'h0;
  assign bus1.ack = bus1.stb;
  assign bus1.dat_sm = 32'h0;
  always @(posedge clk) begin
    wcnt <= (!bus0.stb || bus0.ack || hold) ? 0 : wcnt + 1;
    cyc_n <= cyc_n + 1;
    if (bus0.stb && bus0.ack) begin
      log0.push_back('{bus0.adr, bus0.dat_ms, cyc_n});
      if (bus0.we) mem[bus0.adr[12:2]] <= bus0.dat_ms;
    end
    if (bus1.stb && bus1.ack) log1.push_back('{bus1.adr, bus1.dat_ms, cyc_n});
    if (frame_done0) fd0 <= fd0 + 1;
    if (frame_done1) begin
      fd1 <= fd1 + 1;
      fd1_cyc <= cyc_n;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // streams words base+i (sof at indices sa/sb) into DUT d until pushed and drained
  task automatic drive(input int d, input int n, input logic [31:0] base, input int sa,
                       input int sb, input int hold_cycles, input int budget);
    int idx = 0, t = 0;
    logic p_stb = 0, p_ack = 0, exp_rdy = 0;
    logic [31:0] p_adr = 0, p_dat = 0;
    while ((idx < n || (d == 0 ? bus0.stb : bus1.stb)) && t < budget) begin
      hold = t < hold_cycles;
      in_valid0 = d == 0 && idx < n;
      in_valid1 = d == 1 && idx < n;
      in_data = base + 32'(idx);
      in_sof = idx == sa || idx == sb;
      if (d == 0) begin
        if (hold_cycles > 0 && t == hold_cycles) begin
          chk("fill_count", 32'(idx), 32'd8);
          chk("fill_in_ready", in_ready0, 1'b0);
        end
        if (p_stb && !p_ack) begin
          chk("hold_stb", bus0.stb, 1'b1);
          chk("hold_adr", bus0.adr, p_adr);
          chk("hold_dat", bus0.dat_ms, p_dat);
        end
        if (exp_rdy) chk("full_pop_ready", in_ready0, 1'b1);
        exp_rdy = bus0.stb && bus0.ack && !in_ready0;
        p_stb = bus0.stb;
        p_ack = bus0.ack;
        p_adr = bus0.adr;
        p_dat = bus0.dat_ms;
      end
      if (idx < n && (d == 0 ? in_ready0 : in_ready1)) idx++;
      @(negedge clk);
      t++;
    end
    in_valid0 = 0;
    in_valid1 = 0;
    in_sof = 0;
    hold = 0;
    chk("drive_timeout", 32'(t < budget), 32'd1);
  endtask
  initial begin
    int n0, bad;
    logic [31:0] e4 [5];
    e4 = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h8};
    repeat (2) @(negedge clk);
    chk("rst_stb", bus0.stb, 1'b0);
    chk("rst_cyc", bus0.cyc, 1'b0);
    chk("rst_we", bus0.we, 1'b0);
    chk("rst_sel", bus0.sel, 4'h0);
    chk("rst_adr", bus0.adr, 32'h0);
    chk("rst_dat", bus0.dat_ms, 32'h0);
    chk("rst_fd", frame_done0, 1'b0);
    chk("rst_in_ready", in_ready0, 1'b0);
    rst = 0;
    in_valid0 = 1;
    in_sof = 1;
    in_data = 32'h11111111;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t1_stb", bus0.stb, 1'b1);
      chk("t1_adr", bus0.adr, 32'(4 * i));
      chk("t1_dat", bus0.dat_ms, 32'h11111111 * 32'(i + 1));
      chk("t1_sel", bus0.sel, 4'hF);
      in_sof = 0;
      in_data = 32'h11111111 * 32'(i + 2);
      in_valid0 = i < 3;
      @(negedge clk);
    end
    chk("t1_idle", bus0.stb, 1'b0);
    chk("t1_count", 32'(log0.size()), 32'd4);
    log0.delete();
    ack_delay = 2;
    drive(0, 12, 32'hA0000000, 0, -1, 10, 200);
    chk("t2_count", 32'(log0.size()), 32'd12);
    for (int i = 0; i < 12 && i < log0.size(); i++) begin
      chk("t2_adr", log0[i].adr, 32'(4 * i));
      chk("t2_dat", log0[i].dat, 32'hA0000000 + 32'(i));
    end
    ack_delay = 0;
    n0 = log0.size();
    force_ack = 1;
    repeat (2) @(negedge clk);
    chk("idle_ack_stb", bus0.stb, 1'b0);
    chk("idle_ack_log", 32'(log0.size()), 32'(n0));
    force_ack = 0;
    log0.delete();
    drive(0, 1, 32'hBEEF0000, -1, -1, 0, 50);
    chk("idle_ack_adr", log0.size() > 0 ? log0[0].adr : 32'hFFFFFFFF, 32'h30);
    log0.delete();
    drive(1, 6, 32'h60000000, 0, -1, 0, 100);
    chk("t3_count", 32'(log1.size()), 32'd6);
    for (int i = 0; i < 6 && i < log1.size(); i++)
      chk("t3_adr", log1[i].adr, 32'(4 * (i % 4)));
    chk("t3_fd_count", 32'(fd1), 32'd1);
    chk("t3_fd_cycle", 32'(fd1_cyc), log1.size() > 3 ? 32'(log1[3].cyc + 1) : 32'hFFFFFFFF);
    drive(0, 5, 32'h40000000, 0, 2, 0, 100);
    chk("t4_count", 32'(log0.size()), 32'd5);
    for (int i = 0; i < 5 && i < log0.size(); i++) begin
      chk("t4_adr", log0[i].adr, e4[i]);
      chk("t4_dat", log0[i].dat, 32'h40000000 + 32'(i));
    end
    @(negedge clk);
    chk("t4_no_fd", 32'(fd0), 32'd0);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid0 = 1;
      in_sof = i == 0;
      in_data = 32'hDEAD0000 + 32'(i);
      @(negedge clk);
    end
    in_valid0 = 0;
    in_sof = 0;
    chk("t5_pre_stb", bus0.stb, 1'b1);
    chk("t5_pre_adr", bus0.adr, 32'h0);
    rst = 1;
    @(negedge clk);
    chk("t5_rst_stb", bus0.stb, 1'b0);
    chk("t5_rst_cyc", bus0.cyc, 1'b0);
    chk("t5_rst_in_ready", in_ready0, 1'b0);
    rst = 0;
    hold = 0;
    log0.delete();
    repeat (3) @(negedge clk);
    chk("t5_post_stb", bus0.stb, 1'b0);
    chk("t5_post_log", 32'(log0.size()), 32'd0);
    drive(0, 2, 32'hC0DE0000, 0, -1, 0, 50);
    chk("t5_count", 32'(log0.size()), 32'd2);
    for (int i = 0; i < 2 && i < log0.size(); i++) begin
      chk("t5_adr", log0[i].adr, 32'(4 * i));
      chk("t5_dat", log0[i].dat, 32'hC0DE0000 + 32'(i));
    end
    log0.delete();
    drive(0, 2048, 32'h5A5A0000, 0, -1, 0, 2200);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 2048; i++)
      if (mem[i] !== 32'h5A5A0000 + 32'(i)) bad++;
    chk("t6_mem_bad", 32'(bad), 32'd0);
    chk("t6_count", 32'(log0.size()), 32'd2048);
    chk("t6_span", log0.size() == 2048 ? 32'(log0[2047].cyc - log0[0].cyc) : 32'hFFFFFFFF, 32'd2047);
    chk("t6_fd", 32'(fd0), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
